ram_word_master: RTL and testbench

Word-access initiator for the 1024-byte, byte-wide, simple-dual-port RAM. It accepts 32-bit read/write requests with byte enables from a core-side port and issues them as four sequential byte accesses on the RAM's write and read ports. It captures the RAM's registered one-cycle-latency read data into a word. It sits between a bus slave or debugger and the byte RAM.

---
 rtl/ram_word_pkg.sv | 13 +
 rtl/ram_word_master_if.sv | 32 +++
 rtl/ram_word_master.sv | 131 +++++++++++++
 tb/tb_ram_word_master.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_word_pkg.sv
// Shared types and helpers for the word-to-byte RAM initiator.
package ram_word_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} rwm_state_t;

  localparam int WORD_BYTES = 4;

  // Pick byte k (little-endian lane order) out of a 32-bit word.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/ram_word_master_if.sv
// Core-side request port and byte-RAM port of the word initiator.
interface ram_word_master_if
  import ram_word_pkg::*;
#(
  parameter int AW = 10
) ();

  logic                    i_req;
  logic                    i_we;
  logic [AW-1:0]           i_addr;
  logic [31:0]             i_wdata;
  logic [WORD_BYTES-1:0]   i_be;
  logic                    o_ready;
  logic                    o_ack;
  logic [31:0]             o_rdata;
  logic                    ram_we;
  logic [AW-1:0]           ram_waddr;
  logic [7:0]              ram_wdata;
  logic [AW-1:0]           ram_raddr;
  logic [7:0]              ram_rdata;

  modport master (
    input  i_req, i_we, i_addr, i_wdata, i_be, ram_rdata,
    output o_ready, o_ack, o_rdata, ram_we, ram_waddr, ram_wdata, ram_raddr
  );

  modport slave (
    output i_req, i_we, i_addr, i_wdata, i_be, ram_rdata,
    input  o_ready, o_ack, o_rdata, ram_we, ram_waddr, ram_wdata, ram_raddr
  );

endinterface

// File: rtl/ram_word_master.sv
// Splits 32-bit requests into four sequential byte accesses on a byte-wide
// simple-dual-port RAM and reassembles read bytes into a word.
module ram_word_master
  import ram_word_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_word_master_if.master bus
);

  localparam int WW = AW - 2;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WR   = WR;
  localparam logic [1:0] ST_RD   = RD;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [2:0] LAST_BYTE = 3'(WORD_BYTES - 1);
  localparam logic [2:0] RD_LAST   = 3'(WORD_BYTES);

  logic [1:0]    state_r;
  logic [2:0]    cnt_r;
  logic [WW-1:0] word_r;
  logic [31:0]   wdata_r;
  logic [3:0]    be_r;
  logic          ready_r;
  logic          ack_r;
  logic [31:0]   rdata_r;
  logic          ram_we_r;
  logic [AW-1:0] ram_waddr_r;
  logic [7:0]    ram_wdata_r;
  logic [AW-1:0] ram_raddr_r;

  logic [1:0]    nxt_idx_s;
  logic [1:0]    cap_idx_s;
  logic          addr_lo_unused_s;

  // Word requests are always aligned; the low address bits carry no meaning.
  assign addr_lo_unused_s = ^bus.i_addr[1:0];

  assign nxt_idx_s = cnt_r[1:0] + 2'd1;
  // Read data trails the address by one cycle, so byte cnt-1 arrives now.
  assign cap_idx_s = cnt_r[1:0] - 2'd1;

  // Request sequencer: accept, byte-by-byte write or read, one-cycle ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      word_r      <= '0;
      wdata_r     <= 32'd0;
      be_r        <= 4'd0;
      ready_r     <= 1'b1;
      ack_r       <= 1'b0;
      rdata_r     <= 32'd0;
      ram_we_r    <= 1'b0;
      ram_waddr_r <= '0;
      ram_wdata_r <= 8'd0;
      ram_raddr_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_req) begin
            word_r  <= bus.i_addr[AW-1:2];
            wdata_r <= bus.i_wdata;
            be_r    <= bus.i_be;
            cnt_r   <= 3'd0;
            ready_r <= 1'b0;
            if (bus.i_we) begin
              state_r     <= ST_WR;
              ram_we_r    <= bus.i_be[0];
              ram_waddr_r <= {bus.i_addr[AW-1:2], 2'b00};
              ram_wdata_r <= get_byte(bus.i_wdata, 2'd0);
            end else begin
              state_r     <= ST_RD;
              ram_raddr_r <= {bus.i_addr[AW-1:2], 2'b00};
            end
          end
        end
        ST_WR: begin
          if (cnt_r == LAST_BYTE) begin
            state_r  <= ST_DONE;
            ram_we_r <= 1'b0;
            ack_r    <= 1'b1;
          end else begin
            cnt_r       <= cnt_r + 3'd1;
            ram_we_r    <= be_r[nxt_idx_s];
            ram_waddr_r <= {word_r, nxt_idx_s};
            ram_wdata_r <= get_byte(wdata_r, nxt_idx_s);
          end
        end
        ST_RD: begin
          if (cnt_r != 3'd0) begin
            rdata_r[{cap_idx_s, 3'b000} +: 8] <= bus.ram_rdata;
          end
          if (cnt_r == RD_LAST) begin
            state_r <= ST_DONE;
            ack_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 3'd1;
            if (cnt_r < LAST_BYTE) begin
              ram_raddr_r <= {word_r, nxt_idx_s};
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_IDLE;
          ack_r    <= 1'b0;
          ready_r  <= 1'b1;
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready   = ready_r;
  assign bus.o_ack     = ack_r;
  assign bus.o_rdata   = rdata_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_waddr = ram_waddr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.ram_raddr = ram_raddr_r;

endmodule

// File: tb/tb_ram_word_master.sv
// Bench for ram_word_master: byte RAM responder plus a word-level reference array.
module tb_ram_word_master;
  import ram_word_pkg::*;

  localparam int AW = 10;
  localparam logic [AW-1:0] NOISE_ADDR = 10'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_word_master_if #(.AW(AW)) bus ();
  ram_word_master #(.AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  logic [7:0]    mem     [0:1023];
  logic [7:0]    ref_mem [0:1023];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [7:0]    bd_data = 8'd0;
  int cyc = 0;
  int ack_total = 0;
  int req_done = 0;
  int checks_cnt = 0;
  int errors_cnt = 0;

  // Byte RAM: registered read returns old data on a same-address collision.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_raddr];
    cyc <= cyc + 1;
    if (rst_n && bus.o_ack) ack_total <= ack_total + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[{a[AW-1:2], 2'(k)}];
    return w;
  endfunction

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mem[{a[AW-1:2], 2'(k)}];
    return w;
  endfunction

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  // One word request; called just after a falling edge with the block idle.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input bit keep, input bit noise,
                       output int lat, output int ack_t, output logic [31:0] rd);
    int n;
    logic [3:0] wep;
    logic [31:0] exp_rd;
    n = 0;
    wep = 4'h0;
    exp_rd = ref_word(addr);
    bus.i_req = 1'b1; bus.i_we = we; bus.i_addr = addr; bus.i_wdata = wd; bus.i_be = be;
    while (!bus.o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("accept_wait", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    if (!keep) bus.i_req = 1'b0;
    lat = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat <= 4) wep[lat-1] = bus.ram_we;
      if (noise && lat == 2) begin
        bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = NOISE_ADDR;
        bus.i_wdata = $urandom; bus.i_be = 4'hF;
      end
      if (noise && lat == 3) bus.i_req = 1'b0;
      if (bus.o_ack) break;
    end
    ack_t = cyc;
    rd = bus.o_rdata;
    check_val("ack_latency", 32'(lat), we ? 32'd5 : 32'd6);
    check_val("we_pattern", {28'd0, wep}, we ? {28'd0, be} : 32'd0);
    if (we) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) ref_mem[{addr[AW-1:2], 2'(k)}] = wd[8*k +: 8];
    end else begin
      check_val("rdata", rd, exp_rd);
    end
    req_done++;
    @(negedge clk);
    check_val("ack_pulse", 32'(bus.o_ack), 32'd0);
    check_val("ready_return", 32'(bus.o_ready), 32'd1);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ack_t, prev_t, exp_sp;
    logic [31:0] rd, r_wd;
    logic [AW-1:0] r_addr;
    logic [3:0] r_be;
    logic r_we, prev_we;
    logic [7:0] old2, old3;

    bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wdata = 32'd0; bus.i_be = 4'd0;
    prev_t = 0; prev_we = 1'b0;

    // Preload RAM with random contents while the block is held in reset.
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = 10'(i); bd_data = 8'($urandom);
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    @(negedge clk);
    check_val("rst_ready", 32'(bus.o_ready), 32'd1);
    check_val("rst_ack", 32'(bus.o_ack), 32'd0);
    check_val("rst_rdata", bus.o_rdata, 32'd0);
    check_val("rst_we", 32'(bus.ram_we), 32'd0);
    check_val("rst_waddr", 32'(bus.ram_waddr), 32'd0);
    check_val("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    check_val("rst_raddr", 32'(bus.ram_raddr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic word write then read back.
    issue(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, lat, ack_t, rd);
    issue(1'b0, 10'h010, 32'd0, 4'h0, 1'b0, 1'b0, lat, ack_t, rd);
    check_val("t1_rdata", rd, 32'hDEADBEEF);
    check_val("t1_bytes", mem_word(10'h010), 32'hDEADBEEF);

    // Partial byte-enable write over a known word.
    issue(1'b1, 10'h020, 32'h11223344, 4'hF, 1'b0, 1'b0, lat, ack_t, rd);
    issue(1'b1, 10'h020, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0, lat, ack_t, rd);
    issue(1'b0, 10'h020, 32'd0, 4'h0, 1'b0, 1'b0, lat, ack_t, rd);
    check_val("t2_rdata", rd, 32'h11BB33DD);

    // Top-of-memory word with i_req held across both requests.
    issue(1'b1, 10'h3FC, 32'h01234567, 4'hF, 1'b1, 1'b0, lat, ack_t, rd);
    issue(1'b0, 10'h3FF, 32'd0, 4'h0, 1'b1, 1'b0, lat, ack_t, rd);
    bus.i_req = 1'b0;
    check_val("t3_rdata", rd, 32'h01234567);
    check_val("t3_untouched", 32'(mem_diffs()), 32'd0);

    // Stray requests while busy must be dropped.
    issue(1'b1, 10'h080, 32'h5A5AA5A5, 4'hF, 1'b0, 1'b1, lat, ack_t, rd);
    issue(1'b0, 10'h080, 32'd0, 4'h0, 1'b0, 1'b1, lat, ack_t, rd);
    check_val("t4_rdata", rd, 32'h5A5AA5A5);
    check_val("t4_noise_mem", mem_word(NOISE_ADDR), ref_word(NOISE_ADDR));
    check_val("t4_acks", 32'(ack_total), 32'(req_done));

    // Reset after two bytes of a write.
    old2 = mem[10'h042];
    old3 = mem[10'h043];
    bus.i_req = 1'b1; bus.i_we = 1'b1; bus.i_addr = 10'h040;
    bus.i_wdata = 32'hCAFEF00D; bus.i_be = 4'hF;
    @(posedge clk);
    #1 bus.i_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("t5_pre_we", 32'(bus.ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("t5_we_drop", 32'(bus.ram_we), 32'd0);
    check_val("t5_ready", 32'(bus.o_ready), 32'd1);
    check_val("t5_ack", 32'(bus.o_ack), 32'd0);
    check_val("t5_rdata", bus.o_rdata, 32'd0);
    ref_mem[10'h040] = 8'h0D;
    ref_mem[10'h041] = 8'hF0;
    @(negedge clk);
    @(negedge clk);
    check_val("t5_bytes01", {16'd0, mem[10'h041], mem[10'h040]}, 32'h0000F00D);
    check_val("t5_bytes23", {16'd0, mem[10'h043], mem[10'h042]}, {16'd0, old3, old2});
    rst_n = 1'b1;
    @(negedge clk);

    // Random continuous traffic against the reference array.
    for (int i = 0; i < 1000; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_addr = 10'($urandom_range(0, 95));
      if ($urandom_range(0, 7) == 0) r_addr = 10'(10'h3F0 + 10'($urandom_range(0, 15)));
      r_wd = $urandom;
      r_be = 4'($urandom);
      issue(r_we, r_addr, r_wd, r_be, 1'b1, 1'b0, lat, ack_t, rd);
      exp_sp = (prev_we ? 6 : 7) + (r_we ? 5 : 6) - (prev_we ? 5 : 6);
      if (i > 0) check_val("ack_spacing", 32'(ack_t - prev_t), 32'(exp_sp));
      prev_t = ack_t;
      prev_we = r_we;
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("final_acks", 32'(ack_total), 32'(req_done));
    check_val("final_mem", 32'(mem_diffs()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
